// File: rtl/spi_multi_pkg.sv
// Shared definitions for the multi-channel SPI master: FSM state encoding,
// SPI mode constants ({cpol,cpha}) and a counter-width helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package spi_multi_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_TRAIL = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LEAD  = ST_LEAD,
        XFER  = ST_XFER,
        TRAIL = ST_TRAIL,
        DONE  = ST_DONE
    } state_t;

    // SPI modes as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Counter width that stays legal when the count range is a single value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period divider plus the SCLK register, with edge strobes.
// Latency: strobes are combinational; SCLK toggles on the clock edge that ends a strobe cycle.
// Backpressure: none; free-running while run/en are asserted by the controller.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   run          divider counts (LEAD/XFER/TRAIL)
//   clr          divider restarts from 0 (LEAD entry)
//   en           SCLK toggling and edge strobes enabled (XFER only)
//   idle_lvl     level SCLK is loaded with whenever en is low
//   sclk         registered serial clock
//   wrap         divider is at its last count of the half-period
//   lead_edge    this cycle ends a half-period and SCLK leaves idle_lvl
//   trail_edge   this cycle ends a half-period and SCLK returns to idle_lvl
module spi_clk_gen
    import spi_multi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    input  logic en,
    input  logic idle_lvl,
    output logic sclk,
    output logic wrap,
    output logic lead_edge,
    output logic trail_edge
);

    localparam int CW = cnt_width(CLK_DIV);

    logic [CW-1:0] cnt;

    assign wrap       = (cnt == CW'(CLK_DIV - 1));
    // Leading edge: SCLK is currently at its idle level and is about to leave it.
    assign lead_edge  = en & wrap & (sclk == idle_lvl);
    assign trail_edge = en & wrap & (sclk != idle_lvl);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (run) begin
                cnt <= wrap ? '0 : cnt + CW'(1);
            end

            if (en) begin
                if (wrap) begin
                    sclk <= ~sclk;
                end
            end else begin
                sclk <= idle_lvl;
            end
        end
    end

endmodule

// File: rtl/spi_multi_master.sv
// N-channel SPI master: shared SCLK / slave-select, independent SDO/SDI per channel.
// Latency: SPIRXAVAIL pulses CLK_DIV*(2*DATA_W+2) cycles after start is accepted.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped, not queued.
//
// Ports:
//   PCLK, PRESET   system clock, asynchronous active-high reset
//   loopback       (only with SPI_LOOPBACK_EN) channels sample their own SPISDO
//   start          transfer request, sampled in IDLE
//   cpol, cpha     SPI mode, latched on accept (cpol also tracked while idle)
//   tx_data        packed words, channel k at [k*DATA_W +: DATA_W]
//   SPISDI         serial inputs, one per channel
//   SPISCLKO       shared serial clock
//   SPISS_N        shared active-low slave select
//   SPISDO         serial outputs, one per channel
//   rx_data        received words, same packing as tx_data
//   SPIRXAVAIL     one-cycle pulse when rx_data is updated
//   busy           high from the accepting edge until DONE ends
//
// Build option: define SPI_LOOPBACK_EN to add the loopback input.
module spi_multi_master
    import spi_multi_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
`ifdef SPI_LOOPBACK_EN
    input  logic                     loopback,
`endif
    input  logic                     start,
    input  logic                     cpol,
    input  logic                     cpha,
    input  logic [N_CH*DATA_W-1:0]   tx_data,
    input  logic [N_CH-1:0]          SPISDI,
    output logic                     SPISCLKO,
    output logic                     SPISS_N,
    output logic [N_CH-1:0]          SPISDO,
    output logic [N_CH*DATA_W-1:0]   rx_data,
    output logic                     SPIRXAVAIL,
    output logic                     busy
);

    localparam int EW = $clog2(2 * DATA_W + 1);

    state_t          state;
    logic [1:0]      mode_q;      // {cpol_q, cpha_q}
    logic [EW-1:0]   edge_cnt;    // SCLK edges already produced in XFER

    logic wrap;
    logic lead_edge;
    logic trail_edge;
    logic accept;
    logic last_edge;
    logic done_entry;
    logic sample_on_lead;
    logic shift_on_lead;
    logic sample_ev;
    logic shift_ev;

    logic [N_CH*DATA_W-1:0] rx_all;

    assign accept     = (state == IDLE) && start;
    assign last_edge  = trail_edge && (edge_cnt == EW'(2 * DATA_W - 1));
    assign done_entry = (state == TRAIL) && wrap;

    assign sample_on_lead = (mode_q == MODE0) || (mode_q == MODE2);
    assign shift_on_lead  = (mode_q == MODE1) || (mode_q == MODE3);

    assign sample_ev = sample_on_lead ? lead_edge : trail_edge;
    // With CPHA=0 the first bit is preloaded at accept, so the final trailing
    // edge has nothing left to shift and SPISDO holds the last bit.
    assign shift_ev  = shift_on_lead ? lead_edge : (trail_edge && !last_edge);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk        (PCLK),
        .rst        (PRESET),
        .run        ((state == LEAD) || (state == XFER) || (state == TRAIL)),
        .clr        (accept),
        .en         (state == XFER),
        // While idle SCLK follows the live cpol input; afterwards the latched one.
        .idle_lvl   ((state == IDLE) ? cpol : mode_q[1]),
        .sclk       (SPISCLKO),
        .wrap       (wrap),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            mode_q     <= MODE0;
            edge_cnt   <= '0;
            busy       <= 1'b0;
            SPISS_N    <= 1'b1;
            SPIRXAVAIL <= 1'b0;
            rx_data    <= '0;
        end else begin
            SPIRXAVAIL <= 1'b0;
            case (state)
                IDLE: begin
                    mode_q[1] <= cpol;
                    if (start) begin
                        mode_q   <= {cpol, cpha};
                        edge_cnt <= '0;
                        busy     <= 1'b1;
                        SPISS_N  <= 1'b0;
                        state    <= LEAD;
                    end
                end
                LEAD: begin
                    if (wrap) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (lead_edge || trail_edge) begin
                        edge_cnt <= edge_cnt + EW'(1);
                    end
                    if (last_edge) begin
                        state <= TRAIL;
                    end
                end
                TRAIL: begin
                    if (wrap) begin
                        state      <= DONE;
                        SPISS_N    <= 1'b1;
                        SPIRXAVAIL <= 1'b1;
                        rx_data    <= rx_all;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [DATA_W-1:0] tx_word;
        logic [DATA_W-1:0] tx_sr;
        logic [DATA_W-1:0] rx_sr;
        logic              sdo_q;
        logic              sdi_bit;
        logic              word_first;
        logic [DATA_W-1:0] word_rest;
        logic              sr_first;
        logic [DATA_W-1:0] sr_rest;

        assign tx_word = tx_data[k*DATA_W +: DATA_W];

`ifdef SPI_LOOPBACK_EN
        assign sdi_bit = loopback ? sdo_q : SPISDI[k];
`else
        assign sdi_bit = SPISDI[k];
`endif

        assign word_first = (MSB_FIRST != 0) ? tx_word[DATA_W-1] : tx_word[0];
        assign word_rest  = (MSB_FIRST != 0) ? {tx_word[DATA_W-2:0], 1'b0}
                                             : {1'b0, tx_word[DATA_W-1:1]};
        assign sr_first   = (MSB_FIRST != 0) ? tx_sr[DATA_W-1] : tx_sr[0];
        assign sr_rest    = (MSB_FIRST != 0) ? {tx_sr[DATA_W-2:0], 1'b0}
                                             : {1'b0, tx_sr[DATA_W-1:1]};

        always_ff @(posedge PCLK or posedge PRESET) begin
            if (PRESET) begin
                tx_sr <= '0;
                rx_sr <= '0;
                sdo_q <= 1'b0;
            end else if (accept) begin
                rx_sr <= '0;
                if (cpha) begin
                    tx_sr <= tx_word;
                end else begin
                    sdo_q <= word_first;
                    tx_sr <= word_rest;
                end
            end else if (done_entry) begin
                sdo_q <= 1'b0;
            end else begin
                if (shift_ev) begin
                    sdo_q <= sr_first;
                    tx_sr <= sr_rest;
                end
                if (sample_ev) begin
                    rx_sr <= (MSB_FIRST != 0) ? {rx_sr[DATA_W-2:0], sdi_bit}
                                              : {sdi_bit, rx_sr[DATA_W-1:1]};
                end
            end
        end

        assign SPISDO[k]                   = sdo_q;
        assign rx_all[k*DATA_W +: DATA_W]  = rx_sr;
    end

endmodule

// File: tb/tb_spi_multi_master.sv
// Self-checking bench for spi_multi_master: a wire-level slave/monitor model
// observes SCLK, SPISDO and SPIRXAVAIL and compares against expectations.
// Works with or without SPI_LOOPBACK_EN (loopback is wired externally when absent).
module tb_spi_multi_master;

    localparam int DW = 8;

    logic pclk   = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    int tests = 0;
    int fails = 0;

    // DUT 0: 2 channels, CLK_DIV=2, MSB first
    logic        start0 = 1'b0, cpol0 = 1'b0, cpha0 = 1'b0, lb0 = 1'b0;
    logic [15:0] tx0 = '0;
    logic [1:0]  slave_sdi = '0;
    logic [1:0]  sdi0, sdo0;
    logic        sclk0, ss0, avail0, busy0;
    logic [15:0] rx0;

    // DUT 1: 4 channels, CLK_DIV=1, LSB first, always looped back
    logic        start1 = 1'b0;
    logic [31:0] tx1 = '0;
    logic [3:0]  sdi1, sdo1;
    logic        sclk1, ss1, avail1, busy1;
    logic [31:0] rx1;

`ifdef SPI_LOOPBACK_EN
    assign sdi0 = slave_sdi;
    assign sdi1 = 4'b0101;
`else
    assign sdi0 = lb0 ? sdo0 : slave_sdi;
    assign sdi1 = sdo1;
`endif

    spi_multi_master #(.N_CH(2), .DATA_W(DW), .CLK_DIV(2), .MSB_FIRST(1)) dut0 (
        .PCLK(pclk), .PRESET(preset),
`ifdef SPI_LOOPBACK_EN
        .loopback(lb0),
`endif
        .start(start0), .cpol(cpol0), .cpha(cpha0), .tx_data(tx0), .SPISDI(sdi0),
        .SPISCLKO(sclk0), .SPISS_N(ss0), .SPISDO(sdo0), .rx_data(rx0),
        .SPIRXAVAIL(avail0), .busy(busy0)
    );

    spi_multi_master #(.N_CH(4), .DATA_W(DW), .CLK_DIV(1), .MSB_FIRST(0)) dut1 (
        .PCLK(pclk), .PRESET(preset),
`ifdef SPI_LOOPBACK_EN
        .loopback(1'b1),
`endif
        .start(start1), .cpol(1'b0), .cpha(1'b0), .tx_data(tx1), .SPISDI(sdi1),
        .SPISCLKO(sclk1), .SPISS_N(ss1), .SPISDO(sdo1), .rx_data(rx1),
        .SPIRXAVAIL(avail1), .busy(busy1)
    );

    // Observations from the last dut0 transfer
    int          obs_edges, obs_lat, obs_pulses, obs_busy_end;
    logic [7:0]  obs_cap [2];
    logic [15:0] obs_rx;

    function automatic logic slave_bit(input logic [15:0] w, input int ch, input int i);
        return w[ch*8 + 7 - i];
    endfunction

    // Runs one dut0 transfer acting as slave and wire monitor; records observations.
    task automatic xfer0(input logic m_cpol, input logic m_cpha, input logic [15:0] m_tx,
                         input logic [15:0] m_slv, input logic m_lb, input logic m_wiggle);
        logic prev, lead, samp;
        int sidx;
        @(negedge pclk);
        cpol0 = m_cpol; cpha0 = m_cpha; tx0 = m_tx; lb0 = m_lb; start0 = 1'b1;
        @(negedge pclk);
        start0 = 1'b0;
        obs_edges = 0; obs_lat = -1; obs_pulses = 0; obs_busy_end = -1;
        obs_cap[0] = '0; obs_cap[1] = '0; obs_rx = '0;
        prev = sclk0; sidx = 0;
        if (!m_cpha) begin
            for (int ch = 0; ch < 2; ch++) slave_sdi[ch] = slave_bit(m_slv, ch, 0);
            sidx = 1;
        end
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge pclk);
            if (m_wiggle && cyc == 9) begin
                tx0 = ~m_tx; cpol0 = ~m_cpol; cpha0 = ~m_cpha;
            end
            if (sclk0 !== prev && ss0 === 1'b0) begin
                lead = (prev == m_cpol);
                obs_edges++;
                samp = m_cpha ? !lead : lead;
                if (samp)
                    for (int ch = 0; ch < 2; ch++) obs_cap[ch] = {obs_cap[ch][6:0], sdo0[ch]};
                if (((m_cpha && lead) || (!m_cpha && !lead)) && sidx < DW) begin
                    for (int ch = 0; ch < 2; ch++) slave_sdi[ch] = slave_bit(m_slv, ch, sidx);
                    sidx++;
                end
            end
            prev = sclk0;
            if (avail0 === 1'b1) begin
                obs_pulses++;
                if (obs_lat < 0) begin obs_lat = cyc; obs_rx = rx0; end
            end
            if (obs_lat >= 0 && cyc == obs_lat + 1) obs_busy_end = int'(busy0);
        end
    endtask

    task automatic test_reset();
        @(negedge pclk);
        tests++; if (sclk0 !== 1'b0) begin fails++; $display("FAIL reset_sclk got=%b exp=0", sclk0); end
        tests++; if (ss0 !== 1'b1) begin fails++; $display("FAIL reset_ss_n got=%b exp=1", ss0); end
        tests++; if (sdo0 !== 2'b00) begin fails++; $display("FAIL reset_sdo got=%b exp=00", sdo0); end
        tests++; if (rx0 !== 16'h0) begin fails++; $display("FAIL reset_rx got=%h exp=0000", rx0); end
        tests++; if (avail0 !== 1'b0 || busy0 !== 1'b0) begin
            fails++; $display("FAIL reset_avail_busy got=%b%b exp=00", avail0, busy0);
        end
        preset = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic prev;
        int edges, pulses, falls;
        logic ss_prev;
        @(negedge pclk); preset = 1'b1;
        @(negedge pclk); preset = 1'b0;
        cpol0 = 1'b1; cpha0 = 1'b0; lb0 = 1'b1; tx0 = 16'($urandom); start0 = 1'b1;
        @(negedge pclk); start0 = 1'b0;
        prev = sclk0; edges = 0;
        for (int cyc = 0; cyc < 40 && edges < 10; cyc++) begin
            @(negedge pclk);
            if (sclk0 !== prev && ss0 === 1'b0) edges++;
            prev = sclk0;
        end
        tests++; if (edges != 10) begin fails++; $display("FAIL rstmid_reach_5bits got=%0d edges exp=10", edges); end
        preset = 1'b1;
        #1;
        tests++; if (ss0 !== 1'b1 || sclk0 !== 1'b0 || busy0 !== 1'b0 || sdo0 !== 2'b00) begin
            fails++; $display("FAIL rstmid_outputs ss=%b sclk=%b busy=%b sdo=%b exp 1 0 0 00", ss0, sclk0, busy0, sdo0);
        end
        @(negedge pclk); preset = 1'b0;
        pulses = 0; falls = 0; ss_prev = ss0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge pclk);
            if (avail0 === 1'b1) pulses++;
            if (ss_prev === 1'b1 && ss0 === 1'b0) falls++;
            ss_prev = ss0;
        end
        tests++; if (pulses != 0 || falls != 0) begin
            fails++; $display("FAIL rstmid_no_pulse pulses=%0d falls=%0d exp 0 0", pulses, falls);
        end
        tests++; if (rx0 !== 16'h0) begin fails++; $display("FAIL rstmid_rx got=%h exp=0000", rx0); end
    endtask

    task automatic test_mode0_loopback();
        logic [15:0] slv;
        slv = 16'($urandom);
        xfer0(1'b0, 1'b0, 16'h4532, slv, 1'b1, 1'b0);
        tests++; if (obs_edges != 16) begin fails++; $display("FAIL m0_edges got=%0d exp=16", obs_edges); end
        tests++; if (obs_lat != 36) begin fails++; $display("FAIL m0_latency got=%0d exp=36", obs_lat); end
        tests++; if (obs_pulses != 1) begin fails++; $display("FAIL m0_pulses got=%0d exp=1", obs_pulses); end
        tests++; if (obs_rx !== 16'h4532) begin fails++; $display("FAIL m0_rx got=%h exp=4532", obs_rx); end
        tests++; if (obs_cap[0] !== 8'h32 || obs_cap[1] !== 8'h45) begin
            fails++; $display("FAIL m0_sdo got=%h/%h exp=32/45", obs_cap[0], obs_cap[1]);
        end
        tests++; if (obs_busy_end != 0) begin fails++; $display("FAIL m0_busy_after_done got=%0d exp=0", obs_busy_end); end
    endtask

    task automatic test_mode3_slave();
        logic [15:0] tx;
        @(negedge pclk); cpol0 = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        tests++; if (sclk0 !== 1'b1) begin fails++; $display("FAIL m3_idle_sclk got=%b exp=1", sclk0); end
        tx = 16'($urandom);
        xfer0(1'b1, 1'b1, tx, 16'hCDAB, 1'b0, 1'b0);
        tests++; if (obs_rx !== 16'hCDAB) begin fails++; $display("FAIL m3_rx got=%h exp=cdab", obs_rx); end
        tests++; if (obs_cap[0] !== tx[7:0] || obs_cap[1] !== tx[15:8]) begin
            fails++; $display("FAIL m3_sdo_msb_first got=%h%h exp=%h", obs_cap[1], obs_cap[0], tx);
        end
        tests++; if (obs_edges != 16 || obs_lat != 36) begin
            fails++; $display("FAIL m3_timing edges=%0d lat=%0d exp 16 36", obs_edges, obs_lat);
        end
    endtask

    task automatic test_start_held();
        int accepts[$];
        int falls[$];
        int pulses[$];
        int t;
        logic ss_prev;
        t = 0;
        while (t < 60) begin accepts.push_back(t); t += 2 * (2 * DW + 2) + 2; end
        @(negedge pclk);
        cpol0 = 1'b0; cpha0 = 1'b0; lb0 = 1'b1; tx0 = 16'($urandom); start0 = 1'b1;
        ss_prev = ss0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge pclk);
            if (ss_prev === 1'b1 && ss0 === 1'b0) falls.push_back(cyc);
            if (avail0 === 1'b1) pulses.push_back(cyc);
            ss_prev = ss0;
            if (cyc == 59) start0 = 1'b0;
        end
        tests++; if (falls.size() != accepts.size()) begin
            fails++; $display("FAIL held_transfers got=%0d exp=%0d", falls.size(), accepts.size());
        end
        tests++; if (pulses.size() != accepts.size()) begin
            fails++; $display("FAIL held_pulses got=%0d exp=%0d", pulses.size(), accepts.size());
        end
        tests++; if (falls.size() < 2 || pulses.size() < 1 || falls[1] != accepts[1] || falls[1] - pulses[0] != 2) begin
            fails++; $display("FAIL held_second_fall falls=%0d pulses=%0d exp second fall at %0d, 2 after first DONE",
                              falls.size(), pulses.size(), accepts[1]);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] cap [4];
        logic prev;
        int edges, lat;
        logic [31:0] got_rx;
        for (int ch = 0; ch < 4; ch++) cap[ch] = '0;
        @(negedge pclk);
        tx1 = {8'h88, 8'h64, 8'h97, 8'hFF}; start1 = 1'b1;
        @(negedge pclk); start1 = 1'b0;
        prev = sclk1; edges = 0; lat = -1; got_rx = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge pclk);
            if (sclk1 !== prev && ss1 === 1'b0) begin
                edges++;
                if (prev == 1'b0)
                    for (int ch = 0; ch < 4; ch++) cap[ch] = {sdo1[ch], cap[ch][7:1]};
            end
            prev = sclk1;
            if (avail1 === 1'b1 && lat < 0) begin lat = cyc; got_rx = rx1; end
        end
        tests++; if (lat != 18) begin fails++; $display("FAIL lsb_latency got=%0d exp=18", lat); end
        tests++; if (got_rx !== tx1) begin fails++; $display("FAIL lsb_rx got=%h exp=%h", got_rx, tx1); end
        tests++; if ({cap[3], cap[2], cap[1], cap[0]} !== tx1 || edges != 16) begin
            fails++; $display("FAIL lsb_wire got=%h%h%h%h edges=%0d exp=%h edges=16", cap[3], cap[2], cap[1], cap[0], edges, tx1);
        end
    endtask

    task automatic test_mid_change();
        logic [15:0] tx;
        logic m_cpha;
        tx = 16'($urandom);
        m_cpha = 1'($urandom);
        xfer0(1'b0, m_cpha, tx, 16'($urandom), 1'b1, 1'b1);
        tests++; if (obs_rx !== tx) begin fails++; $display("FAIL mid_rx got=%h exp=%h", obs_rx, tx); end
        tests++; if ({obs_cap[1], obs_cap[0]} !== tx || obs_edges != 16 || obs_lat != 36) begin
            fails++; $display("FAIL mid_waveform sdo=%h%h edges=%0d lat=%0d exp=%h 16 36",
                              obs_cap[1], obs_cap[0], obs_edges, obs_lat, tx);
        end
    endtask

    task automatic test_random();
        logic [15:0] tx, slv, exp_rx;
        logic m_cpol, m_cpha, m_lb;
        for (int n = 0; n < 4; n++) begin
            tx = 16'($urandom); slv = 16'($urandom);
            m_cpol = 1'($urandom); m_cpha = 1'($urandom); m_lb = 1'($urandom);
            exp_rx = m_lb ? tx : slv;
            xfer0(m_cpol, m_cpha, tx, slv, m_lb, 1'b0);
            tests++; if (obs_rx !== exp_rx || obs_lat != 36) begin
                fails++; $display("FAIL rand%0d_rx mode=%b%b lb=%b got=%h lat=%0d exp=%h lat=36",
                                  n, m_cpol, m_cpha, m_lb, obs_rx, obs_lat, exp_rx);
            end
            tests++; if ({obs_cap[1], obs_cap[0]} !== tx) begin
                fails++; $display("FAIL rand%0d_sdo got=%h%h exp=%h", n, obs_cap[1], obs_cap[0], tx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_mode0_loopback();
        test_mode3_slave();
        test_start_held();
        test_lsb_first();
        test_mid_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
